// File: rtl/div_period_monitor.sv
// div_period_monitor: measures the period and high time of a divided clock
// sampled as a level in the clk domain, checks the period against
// EXP_PERIOD +/- TOL, and reports lock / sticky error status.
// Optional duty-cycle check is compiled in with DIV_PERIOD_MONITOR_DUTY_CHK_EN.
module div_period_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 20,
  parameter int TOL        = 0,
  parameter int LOCK_N     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             lock,
  output logic             err,
  output logic             err_duty
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Window bounds; the lower bound never drops below one cycle.
  localparam int LO_I = (EXP_PERIOD - TOL < 1) ? 1 : (EXP_PERIOD - TOL);
  localparam int HI_I = EXP_PERIOD + TOL;
  localparam logic [CNT_W:0] LO_B = (CNT_W+1)'(LO_I);
  localparam logic [CNT_W:0] HI_B = (CNT_W+1)'(HI_I);

  localparam int GC_W = $clog2(LOCK_N + 1);
  localparam logic [GC_W-1:0] GC_MAX = GC_W'(LOCK_N);

  logic [1:0]       state;
  logic             div_d;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [GC_W-1:0]  good_cnt;

  logic             rise;
  logic             per_good;
  logic             duty_bad;
  logic [GC_W-1:0]  gc_next;

  // Edge detect, period window check and saturating good-period count.
  always_comb begin
    rise     = div_in & ~div_d;
    per_good = ({1'b0, per_cnt} >= LO_B) && ({1'b0, per_cnt} <= HI_B);
    gc_next  = (good_cnt == GC_MAX) ? GC_MAX : good_cnt + 1'b1;
  end

`ifdef DIV_PERIOD_MONITOR_DUTY_CHK_EN
  // A 50% duty cycle means the high time is exactly half the period.
  assign duty_bad = ({hi_cnt, 1'b0} != {1'b0, per_cnt});
`else
  assign duty_bad = 1'b0;
  assign err_duty = 1'b0;
`endif

  // Measurement FSM, counters, published results and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      div_d      <= 1'b0;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      good_cnt   <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      lock       <= 1'b0;
      err        <= 1'b0;
`ifdef DIV_PERIOD_MONITOR_DUTY_CHK_EN
      err_duty   <= 1'b0;
`endif
    end else begin
      div_d      <= div_in;
      meas_valid <= 1'b0;
      // Clear first; any set later in this block takes priority.
      if (err_clr) err <= 1'b0;
`ifdef DIV_PERIOD_MONITOR_DUTY_CHK_EN
      if (err_clr) err_duty <= 1'b0;
`endif
      if (!en) begin
        // Disabled: drop any partial measurement, keep last results and errors.
        state    <= S_IDLE;
        per_cnt  <= '0;
        hi_cnt   <= '0;
        good_cnt <= '0;
        lock     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: state <= S_WAIT;
          S_WAIT: begin
            // First rise only arms; nothing to measure against yet.
            if (rise) begin
              per_cnt <= CNT_W'(1);
              hi_cnt  <= CNT_W'(1);
              state   <= S_MEAS;
            end
          end
          S_MEAS: begin
            if (rise) begin
              period     <= per_cnt;
              high_time  <= hi_cnt;
              meas_valid <= 1'b1;
              per_cnt    <= CNT_W'(1);
              hi_cnt     <= CNT_W'(1);
              if (!per_good) begin
                err      <= 1'b1;
                good_cnt <= '0;
                lock     <= 1'b0;
              end else if (duty_bad) begin
                good_cnt <= '0;
                lock     <= 1'b0;
              end else begin
                good_cnt <= gc_next;
                lock     <= (gc_next == GC_MAX);
              end
`ifdef DIV_PERIOD_MONITOR_DUTY_CHK_EN
              if (duty_bad) err_duty <= 1'b1;
`endif
            end else if (per_cnt == CNT_MAX) begin
              // Divider stalled: flag it and re-arm on the next edge.
              err      <= 1'b1;
              lock     <= 1'b0;
              good_cnt <= '0;
              state    <= S_WAIT;
            end else begin
              per_cnt <= per_cnt + 1'b1;
              if (div_in && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_period_monitor.sv
// Directed bench for div_period_monitor. Three instances share stimulus:
// a = defaults, b = TOL 2, c = CNT_W 8 (short timeout).
module tb_div_period_monitor;

  logic clk = 1'b0;
  logic rst, en, div_in, err_clr;

  logic [15:0] period_a, high_a, period_b, high_b;
  logic [7:0]  period_c, high_c;
  logic mv_a, lock_a, err_a, ed_a;
  logic mv_b, lock_b, err_b, ed_b;
  logic mv_c, lock_c, err_c, ed_c;

  int n_tests = 0;
  int n_fail  = 0;
  int mvn_a = 0, mvn_b = 0, mvn_c = 0;
  int save_c;

  always #5 clk = ~clk;

  div_period_monitor dut_a (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .err_clr(err_clr),
    .period(period_a), .high_time(high_a), .meas_valid(mv_a),
    .lock(lock_a), .err(err_a), .err_duty(ed_a));

  div_period_monitor #(.TOL(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .err_clr(err_clr),
    .period(period_b), .high_time(high_b), .meas_valid(mv_b),
    .lock(lock_b), .err(err_b), .err_duty(ed_b));

  div_period_monitor #(.CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .err_clr(err_clr),
    .period(period_c), .high_time(high_c), .meas_valid(mv_c),
    .lock(lock_c), .err(err_c), .err_duty(ed_c));

  // Count measurement pulses per instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (mv_a) mvn_a++;
    if (mv_b) mvn_b++;
    if (mv_c) mvn_c++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One divided period: hi cycles high then lo cycles low, optional err_clr at the rise.
  task automatic wave(input int hi, input int lo, input logic clr_at_rise);
    div_in  = 1'b1;
    err_clr = clr_at_rise;
    tick();
    err_clr = 1'b0;
    repeat (hi - 1) tick();
    div_in = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; div_in = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_period", 32'(period_a), 0);
    chk("rst_high",   32'(high_a), 0);
    chk("rst_mv",     32'(mv_a), 0);
    chk("rst_lock",   32'(lock_a), 0);
    chk("rst_err",    32'(err_a), 0);
    chk("rst_err_duty", 32'(ed_a), 0);

    rst = 1'b0; en = 1'b1;
    tick(); tick();

    // Lock acquisition on a clean 20-cycle stream.
    wave(10, 10, 1'b0);
    chk("arm_no_mv", 32'(mvn_a), 0);
    wave(10, 10, 1'b0);
    chk("first_mv_cnt", 32'(mvn_a), 1);
    chk("first_period", 32'(period_a), 20);
    chk("first_high",   32'(high_a), 10);
    chk("first_err",    32'(err_a), 0);
    wave(10, 10, 1'b0);
    wave(10, 10, 1'b0);
    chk("lock_after3", 32'(lock_a), 0);
    wave(10, 10, 1'b0);
    chk("lock_after4", 32'(lock_a), 1);
    chk("mv_cnt4",     32'(mvn_a), 4);
    chk("lock_c_after4", 32'(lock_c), 1);

    // One 22-cycle period: error for TOL 0, accepted with TOL 2.
    wave(11, 11, 1'b0);
    wave(10, 10, 1'b0);
    chk("bad_period", 32'(period_a), 22);
    chk("bad_high",   32'(high_a), 11);
    chk("bad_err",    32'(err_a), 1);
    chk("bad_lock",   32'(lock_a), 0);
    chk("tol_period", 32'(period_b), 22);
    chk("tol_err",    32'(err_b), 0);
    chk("tol_lock",   32'(lock_b), 1);
    wave(10, 10, 1'b0);
    wave(10, 10, 1'b0);
    wave(10, 10, 1'b0);
    chk("relock_3", 32'(lock_a), 0);
    wave(10, 10, 1'b0);
    chk("relock_4", 32'(lock_a), 1);
    chk("relock_err_sticky", 32'(err_a), 1);

    // err_clr on its own clears next cycle.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err_a", 32'(err_a), 0);
    chk("clr_err_c", 32'(err_c), 0);

    // Stall: only the 8-bit instance times out.
    save_c = mvn_c;
    repeat (300) tick();
    chk("to_err_c",  32'(err_c), 1);
    chk("to_lock_c", 32'(lock_c), 0);
    chk("to_no_mv_c", 32'(mvn_c), save_c);
    chk("stall_err_a",  32'(err_a), 0);
    chk("stall_lock_a", 32'(lock_a), 1);

    // Resume with err_clr on the rise: set beats clear on a, clear wins on c.
    wave(10, 10, 1'b1);
    chk("setclr_err_a", 32'(err_a), 1);
    chk("long_period_a", 32'(period_a), 321);
    chk("long_lock_a",  32'(lock_a), 0);
    chk("rearm_err_c",  32'(err_c), 0);
    chk("rearm_no_mv_c", 32'(mvn_c), save_c);
    wave(10, 10, 1'b0);
    chk("resume_mv_c",     32'(mvn_c), save_c + 1);
    chk("resume_period_c", 32'(period_c), 20);
    chk("resume_high_c",   32'(high_c), 10);

    // en drop mid-measurement: partial count discarded, results held.
    div_in = 1'b1;
    tick();
    tick();
    en = 1'b0;
    save_c = mvn_a;
    tick(); tick();
    chk("en_off_lock",   32'(lock_a), 0);
    chk("en_off_period", 32'(period_a), 20);
    chk("en_off_no_mv",  32'(mvn_a), save_c);
    div_in = 1'b0;

    // Duty: period 20 with high 8.
    rst = 1'b1; tick(); rst = 1'b0; en = 1'b1;
    tick(); tick();
    wave(8, 12, 1'b0);
    wave(8, 12, 1'b0);
    chk("duty_period", 32'(period_a), 20);
    chk("duty_high",   32'(high_a), 8);
    chk("duty_err",    32'(err_a), 0);
    chk("duty_lock",   32'(lock_a), 0);
`ifdef DIV_PERIOD_MONITOR_DUTY_CHK_EN
    chk("duty_flag", 32'(ed_a), 1);
`else
    chk("duty_flag", 32'(ed_a), 0);
`endif

    // Reset mid-period clears every output.
    div_in = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_period", 32'(period_a), 0);
    chk("midrst_high",   32'(high_a), 0);
    chk("midrst_mv",     32'(mv_a), 0);
    chk("midrst_lock",   32'(lock_a), 0);
    chk("midrst_err",    32'(err_a), 0);
    chk("midrst_err_duty", 32'(ed_a), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_period_monitor.md
Name: div_period_monitor

Overview:
- Downstream stage of the even clock divider. Samples the divided clock output as a level in the system clock domain.
- Measures each divided period and its high time in system clock cycles, checks the period against an expected value, and raises lock and error indications.
- Used to qualify divider output before downstream logic trusts it, and as a self-check in divider benches.

Parameters:
- CNT_W, 16: width of the period and high-time counters and outputs.
- EXP_PERIOD, 20: expected period in clk cycles (2*N for the even divider; default matches N=10).
- TOL, 0: allowed deviation, ± clk cycles, from EXP_PERIOD.
- LOCK_N, 4: consecutive in-tolerance periods required to assert lock.

Ports:
- clk  input  1  system clock; also the clock that drives the divider.
- rst  input  1  synchronous reset, active-high.
- en  input  1  monitor enable.
- div_in  input  1  divided clock from the divider, synchronous to clk.
- err_clr  input  1  one-cycle pulse; clears err and err_duty.
- period  output  CNT_W  last measured period, in clk cycles.
- high_time  output  CNT_W  last measured high time, in clk cycles.
- meas_valid  output  1  one-cycle pulse; period/high_time were updated this cycle.
- lock  output  1  LOCK_N consecutive good periods seen.
- err  output  1  sticky period/timeout error.
- err_duty  output  1  sticky duty error (see Optional Feature).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state changes on the rising edge of clk.
- Reset: period=0, high_time=0, meas_valid=0, lock=0, err=0, err_duty=0, state=IDLE, internal counters=0, div_d=0. Reset mid-measurement discards the partial count.
- Edge detect: div_d registers div_in. rise = div_in & ~div_d.
- IDLE:
  - Entered when en=0.
  - per_cnt/hi_cnt/good_cnt cleared, lock=0.
  - period, high_time, err, err_duty hold.
  - en=1 -> WAIT_EDGE.
- WAIT_EDGE: on rise, per_cnt<=1, hi_cnt<=1, go to MEASURE.
- MEASURE, non-rise cycle:
  - per_cnt+=1; hi_cnt+=div_in.
  - Both saturate at 2^CNT_W-1.
- MEASURE, rise cycle:
  - period<=per_cnt, high_time<=hi_cnt, meas_valid=1 (same register update, visible the cycle after the edge).
  - per_cnt<=1, hi_cnt<=1.
- Period check on each rise in MEASURE:
  - Good when EXP_PERIOD-TOL <= per_cnt <= EXP_PERIOD+TOL. Lower bound is clamped at 1.
  - Good period: good_cnt increments, saturating at LOCK_N. lock=1 once good_cnt reaches LOCK_N.
  - Bad period: err<=1, good_cnt<=0, lock<=0.
- Timeout:
  - Trigger: per_cnt reaches 2^CNT_W-1 without a rise (divider stalled).
  - Action: err<=1, lock<=0, good_cnt<=0, go to WAIT_EDGE. period/high_time unchanged; no meas_valid.
- Error clear: err_clr clears err and err_duty. A set in the same cycle wins over clear.
- en deassert mid-measurement: go to IDLE next cycle, partial measurement dropped, no meas_valid.
- First edge after enable only arms the monitor. The first meas_valid comes at the second rise.

Optional Feature:
- Macro: DIV_PERIOD_MONITOR_DUTY_CHK_EN.
- Defined: on each rise in MEASURE, if 2*hi_cnt != per_cnt, set err_duty (sticky), clear good_cnt and drop lock.
- Not defined: err_duty tied 0; lock depends on period only; no duty logic synthesised.

Test Plan:
- Reset, en=1, div_in toggling every 10 clk -> first meas_valid at second rise; period=20, high_time=10, err=0. lock=1 after the 4th good meas_valid.
- Locked stream, then one period of 22 clk (high 11) -> meas_valid with period=22, err=1, lock=0. Lock reasserts after 4 further 20-cycle periods.
- Same stream with TOL=2 -> period 22 accepted, err stays 0, lock stays 1.
- CNT_W=8, div_in held low after lock -> err=1, lock=0 when per_cnt reaches 255, state WAIT_EDGE. Resuming toggles gives a valid period=20 at the second rise.
- err_clr pulse in the same cycle as a bad-period rise -> err stays 1. err_clr alone -> err=0 next cycle.
- With DIV_PERIOD_MONITOR_DUTY_CHK_EN, period 20 with high 8 -> err_duty=1, lock=0, err=0. rst=1 mid-period -> all outputs 0 next cycle.
